// File: rtl/xbar_sched.sv
// Per-output round-robin scheduler for a NUM_ELEM x NUM_ELEM crossbar.
// Zero-cycle grant; multi-beat packets keep their output until the last beat is accepted.
module xbar_sched #(
   parameter  int NUM_ELEM = 6,
   localparam int DW       = $clog2(NUM_ELEM)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_ELEM-1:0]         req_valid_i,
   input  logic [NUM_ELEM-1:0][DW-1:0] req_dst_i,
   input  logic [NUM_ELEM-1:0]         req_last_i,
   output logic [NUM_ELEM-1:0]         req_ready_o,
   output logic [NUM_ELEM-1:0][DW-1:0] sel_o,
   output logic [NUM_ELEM-1:0]         out_valid_o,
   output logic [NUM_ELEM-1:0]         out_last_o,
   input  logic [NUM_ELEM-1:0]         out_ready_i,
   output logic [NUM_ELEM-1:0]         busy_o
);

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t        state_q [NUM_ELEM];
   state_t        state_d [NUM_ELEM];
   logic [DW-1:0] owner_q [NUM_ELEM];
   logic [DW-1:0] owner_d [NUM_ELEM];
   logic [DW-1:0] ptr_q   [NUM_ELEM];
   logic [DW-1:0] ptr_d   [NUM_ELEM];

   logic [DW-1:0]       eff_dst [NUM_ELEM];
   logic [DW-1:0]       win_idx [NUM_ELEM];
   logic [NUM_ELEM-1:0] win_vld;
   logic [NUM_ELEM-1:0] win_acc;
   logic [NUM_ELEM-1:0] win_end;

   // Out-of-range destinations wrap the same way the crossbar does.
   always_comb begin : norm_dst
      for (int k = 0; k < NUM_ELEM; k++) begin
         if (int'(req_dst_i[k]) < NUM_ELEM) begin
            eff_dst[k] = req_dst_i[k];
         end else begin
            eff_dst[k] = DW'(int'(req_dst_i[k]) - NUM_ELEM);
         end
      end
   end

   always_comb begin : arbitrate
      int            c;
      logic [DW-1:0] ci;
      c  = 0;
      ci = '0;
      for (int j = 0; j < NUM_ELEM; j++) begin
         win_vld[j] = 1'b0;
         win_idx[j] = '0;
         if (state_q[j] == OWNED) begin
            // An owned output only listens to its owner; a gap leaves it idle-valid.
            win_idx[j] = owner_q[j];
            win_vld[j] = req_valid_i[owner_q[j]] && (eff_dst[owner_q[j]] == DW'(j));
         end else begin
            for (int i = 0; i < NUM_ELEM; i++) begin
               c = int'(ptr_q[j]) + i;
               if (c >= NUM_ELEM) c = c - NUM_ELEM;
               ci = DW'(c);
               if (!win_vld[j] && req_valid_i[ci] && (eff_dst[ci] == DW'(j))) begin
                  win_vld[j] = 1'b1;
                  win_idx[j] = ci;
               end
            end
         end
         win_acc[j] = win_vld[j] && out_ready_i[j];
         win_end[j] = win_acc[j] && req_last_i[win_idx[j]];
      end
   end

   always_comb begin : drive_outputs
      req_ready_o = '0;
      sel_o       = '0;
      out_valid_o = '0;
      out_last_o  = '0;
      busy_o      = '0;
      if (!rst_i) begin
         for (int j = 0; j < NUM_ELEM; j++) begin
            sel_o[j]       = win_vld[j] ? win_idx[j] : '0;
            out_valid_o[j] = win_vld[j];
            out_last_o[j]  = win_vld[j] && req_last_i[win_idx[j]];
            busy_o[j]      = (state_q[j] == OWNED);
            for (int k = 0; k < NUM_ELEM; k++) begin
               if (win_acc[j] && (win_idx[j] == DW'(k))) req_ready_o[k] = 1'b1;
            end
         end
      end
   end

   always_comb begin : next_state
      for (int j = 0; j < NUM_ELEM; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = ptr_q[j];
         case (state_q[j])
            IDLE: begin
               // A stalled first beat is locked too, so the grant cannot move.
               if (win_vld[j] && !win_end[j]) begin
                  state_d[j] = OWNED;
                  owner_d[j] = win_idx[j];
               end
            end
            OWNED: begin
               if (win_end[j]) state_d[j] = IDLE;
            end
            default: state_d[j] = IDLE;
         endcase
         if (win_end[j]) begin
            ptr_d[j] = (int'(win_idx[j]) == NUM_ELEM - 1) ? '0 : win_idx[j] + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int j = 0; j < NUM_ELEM; j++) begin
            state_q[j] <= IDLE;
            owner_q[j] <= '0;
            ptr_q[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_ELEM; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
         end
      end
   end

endmodule
